ps2_mouse_tracker: RTL

Receive-only PS/2 mouse decoder and absolute cursor-position tracker. It deserialises 11-bit PS/2 device-to-host frames, assembles standard 3-byte stream-mode movement packets, and integrates signed deltas into clamped screen coordinates. It feeds `xpos`/`ypos` and button state to the mouse-overlay drawing stage in the VGA pipeline. Enabling stream mode (host command 0xF4) is handled by a separate host-transmit block and is out of scope.

---
 rtl/ps2_mouse_tracker_if.sv | 26 ++
 rtl/ps2_mouse_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker_if.sv
// PS/2 pins in, cursor position and button state out, between the mouse
// tracker (master) and the overlay stage (slave).
`timescale 1ns/1ps
interface ps2_mouse_tracker_if;
    localparam int unsigned POS_W = 12;

    logic             ps2_clk;
    logic             ps2_data;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             left;
    logic             right;
    logic             middle;
    logic             packet_valid;
    logic             frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output xpos, ypos, left, right, middle, packet_valid, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  xpos, ypos, left, right, middle, packet_valid, frame_err
    );
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Receive-only PS/2 mouse decoder: deserialises device frames, assembles
// 3-byte stream packets and integrates deltas into a clamped cursor position.
`timescale 1ns/1ps
module ps2_mouse_tracker #(
    parameter int unsigned X_MAX   = 799,
    parameter int unsigned Y_MAX   = 599,
    parameter int unsigned X_INIT  = 400,
    parameter int unsigned Y_INIT  = 300,
    parameter int unsigned TIMEOUT = 40000
) (
    input  logic               clk,
    input  logic               rst,
    ps2_mouse_tracker_if.master bus
);
    localparam int unsigned POS_W    = 12;
    localparam int unsigned CALC_W   = 14;
    localparam int unsigned DELTA_W  = 9;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LAST_BIT = 10;
    localparam int unsigned WD_W     = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pkt_state_t;

    logic [1:0]        clk_sync;
    logic              clk_prev;
    logic [1:0]        dat_sync;
    logic              fall_c;

    logic [CNT_W-1:0]  bit_cnt;
    logic [9:0]        shreg;
    logic              byte_rdy;
    logic [7:0]        byte_data;
    logic              frame_err_q;

    pkt_state_t        state;
    logic [2:0]        btn_st;
    logic              x_sign, y_sign, x_ovf, y_ovf;
    logic [7:0]        dx_lo;

    logic [POS_W-1:0]  xpos_q, ypos_q;
    logic              left_q, right_q, middle_q, packet_valid_q;

    logic [WD_W-1:0]   wd_cnt;
    logic              wd_active_c;
    logic              timeout_c;

    logic [DELTA_W-1:0] dx_c, dy_c;
    logic [CALC_W-1:0]  nx_c, ny_c;

    assign fall_c      = ~clk_sync[1] & clk_prev;
    assign wd_active_c = (bit_cnt != '0) || (state != BYTE0);
    assign timeout_c   = (wd_cnt == WD_W'(TIMEOUT));

    // Overflowed axes contribute no motion; PS/2 Y is up-positive, screen Y is down-positive.
    assign dx_c = x_ovf ? '0 : {x_sign, dx_lo};
    assign dy_c = y_ovf ? '0 : {y_sign, byte_data};
    assign nx_c = CALC_W'(xpos_q) + {{(CALC_W-DELTA_W){dx_c[DELTA_W-1]}}, dx_c};
    assign ny_c = CALC_W'(ypos_q) - {{(CALC_W-DELTA_W){dy_c[DELTA_W-1]}}, dy_c};

    function automatic logic [POS_W-1:0] clamp(input logic [CALC_W-1:0] v,
                                               input logic [POS_W-1:0]  vmax);
        if (v[CALC_W-1])
            return '0;
        else if (v > CALC_W'(vmax))
            return vmax;
        else
            return v[POS_W-1:0];
    endfunction

    // Pin synchronisers plus a third clock flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            clk_prev <= 1'b1;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], bus.ps2_clk};
            clk_prev <= clk_sync[1];
            dat_sync <= {dat_sync[0], bus.ps2_data};
        end
    end

    // Frame shifter: start, 8 data LSB-first, odd parity, stop; checked on the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            byte_rdy    <= 1'b0;
            byte_data   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            byte_rdy    <= 1'b0;
            frame_err_q <= 1'b0;
            if (timeout_c) begin
                bit_cnt <= '0;
            end else if (fall_c) begin
                if (bit_cnt == CNT_W'(LAST_BIT)) begin
                    bit_cnt <= '0;
                    if (!shreg[0] && dat_sync[1] && (^shreg[9:1])) begin
                        byte_rdy  <= 1'b1;
                        byte_data <= shreg[8:1];
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    shreg   <= {dat_sync[1], shreg[9:1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Packet assembly and position integration; timeout and frame errors resync to BYTE0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= BYTE0;
            btn_st         <= '0;
            x_sign         <= 1'b0;
            y_sign         <= 1'b0;
            x_ovf          <= 1'b0;
            y_ovf          <= 1'b0;
            dx_lo          <= '0;
            xpos_q         <= POS_W'(X_INIT);
            ypos_q         <= POS_W'(Y_INIT);
            left_q         <= 1'b0;
            right_q        <= 1'b0;
            middle_q       <= 1'b0;
            packet_valid_q <= 1'b0;
        end else begin
            packet_valid_q <= 1'b0;
            if (timeout_c || frame_err_q) begin
                state <= BYTE0;
            end else if (byte_rdy) begin
                case (state)
                    BYTE0: begin
                        if (byte_data[3]) begin
                            btn_st <= byte_data[2:0];
                            x_sign <= byte_data[4];
                            y_sign <= byte_data[5];
                            x_ovf  <= byte_data[6];
                            y_ovf  <= byte_data[7];
                            state  <= BYTE1;
                        end
                    end
                    BYTE1: begin
                        dx_lo <= byte_data;
                        state <= BYTE2;
                    end
                    BYTE2: begin
                        xpos_q         <= clamp(nx_c, POS_W'(X_MAX));
                        ypos_q         <= clamp(ny_c, POS_W'(Y_MAX));
                        left_q         <= btn_st[0];
                        right_q        <= btn_st[1];
                        middle_q       <= btn_st[2];
                        packet_valid_q <= 1'b1;
                        state          <= BYTE0;
                    end
                    default: state <= BYTE0;
                endcase
            end
        end
    end

    // Idle watchdog: aborts partial frames/packets when the device stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (timeout_c || fall_c || !wd_active_c)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    assign bus.xpos         = xpos_q;
    assign bus.ypos         = ypos_q;
    assign bus.left         = left_q;
    assign bus.right        = right_q;
    assign bus.middle       = middle_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.frame_err    = frame_err_q;
endmodule
